// File: rtl/x_piso_pkg.sv
// Shared types and helpers for the x_piso_32_bit serial transmitter.
package x_piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } piso_state_t;

  // Bit count of the per-word bit counter (counts WIDTH-1 down to 0).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/x_piso_32_bit.sv
// Parallel-in serial-out transmitter: WIDTH-bit words arrive on a valid/ready
// handshake and leave MSB-first on o_out, one bit per clock. A one-entry
// holding buffer lets consecutive words stream without idle bits (GAP=0), or
// with exactly GAP idle bit-times between them (GAP>0).
module x_piso_32_bit
  import x_piso_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GAP   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_out,
  output logic             o_frame,
  output logic             o_busy
);

  localparam int unsigned   CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(WIDTH - 1);
  localparam logic [3:0]    GCNT_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  // The parameter GAP hides the GAP state name, so the state is always
  // written package-qualified.
  piso_state_t      r_state;
  logic [WIDTH-1:0] r_hold_q;
  logic             r_hold_valid;
  // The MSB goes straight to o_out on load, so only the remaining WIDTH-1
  // bits are kept; the line sequence is identical to shifting the full word.
  logic [WIDTH-2:0] r_shift_q;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_gcnt;
  logic             r_out;
  logic             r_frame;

  piso_state_t      w_state_n;
  logic [WIDTH-1:0] w_hold_q_n;
  logic             w_hold_valid_n;
  logic [WIDTH-2:0] w_shift_n;
  logic [CW-1:0]    w_cnt_n;
  logic [3:0]       w_gcnt_n;
  logic             w_out_n;
  logic             w_frame_n;

  logic             w_xfer;
  logic             w_src_avail;
  logic [WIDTH-1:0] w_src_word;
  logic             w_load_slot;
  logic             w_load;
  logic             w_bypass;

  assign o_ready = !i_rst && !r_hold_valid;
  assign o_out   = r_out;
  assign o_frame = r_frame;
  assign o_busy  = (r_state != IDLE) || r_hold_valid;

  // Next-state, shifter, counters and holding-buffer update.
  always_comb begin
    w_state_n      = r_state;
    w_hold_q_n     = r_hold_q;
    w_hold_valid_n = r_hold_valid;
    w_shift_n      = r_shift_q;
    w_cnt_n        = r_cnt;
    w_gcnt_n       = r_gcnt;
    w_out_n        = 1'b0;
    w_frame_n      = 1'b0;

    w_xfer      = i_valid && o_ready;
    w_src_avail = r_hold_valid || w_xfer;
    w_src_word  = r_hold_valid ? r_hold_q : i_data;
    w_load_slot = (r_state == IDLE)
               || ((r_state == SHIFT) && (r_cnt == '0) && (GAP == 0))
               || ((r_state == x_piso_pkg::GAP) && (r_gcnt == '0));
    w_load      = w_load_slot && w_src_avail;
    w_bypass    = w_load && !r_hold_valid;

    if (w_load) begin
      w_shift_n = w_src_word[WIDTH-2:0];
      w_out_n   = w_src_word[WIDTH-1];
      w_frame_n = 1'b1;
      w_cnt_n   = CNT_LOAD;
      w_state_n = SHIFT;
    end else begin
      case (r_state)
        SHIFT: begin
          if (r_cnt != '0) begin
            w_out_n   = r_shift_q[WIDTH-2];
            w_shift_n = r_shift_q << 1;
            w_cnt_n   = r_cnt - 1'b1;
          end else if (GAP > 0) begin
            w_gcnt_n  = GCNT_LOAD;
            w_state_n = x_piso_pkg::GAP;
          end else begin
            w_state_n = IDLE;
          end
        end
        x_piso_pkg::GAP: begin
          if (r_gcnt != '0) begin
            w_gcnt_n = r_gcnt - 1'b1;
          end else begin
            w_state_n = IDLE;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end

    if (w_load && r_hold_valid) begin
      w_hold_valid_n = 1'b0;
    end
    if (w_xfer && !w_bypass) begin
      w_hold_q_n     = i_data;
      w_hold_valid_n = 1'b1;
    end
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_hold_q     <= '0;
      r_hold_valid <= 1'b0;
      r_shift_q    <= '0;
      r_cnt        <= '0;
      r_gcnt       <= '0;
      r_out        <= 1'b0;
      r_frame      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_hold_q     <= w_hold_q_n;
      r_hold_valid <= w_hold_valid_n;
      r_shift_q    <= w_shift_n;
      r_cnt        <= w_cnt_n;
      r_gcnt       <= w_gcnt_n;
      r_out        <= w_out_n;
      r_frame      <= w_frame_n;
    end
  end

endmodule

// File: tb/tb_x_piso_32_bit.sv
// Bench for x_piso_32_bit: three instances (GAP = 0, 3, 11) checked every
// cycle against a word-level timing model (each word starts at
// max(accept edge, previous start + WIDTH + GAP)), plus a receiver-side
// deserializer, table-driven directed vectors and a mid-word reset sequence.
module tb_x_piso_32_bit;

  localparam int W  = 32;
  localparam int ND = 3;
  localparam int GAPS [ND] = '{0, 3, 11};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W-1:0]  data [ND];
  logic [ND-1:0] valid, ready, sout, frame, busy;

  for (genvar k = 0; k < ND; k++) begin : g_dut
    x_piso_32_bit #(.WIDTH(W), .GAP(GAPS[k])) u_dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_data (data[k]),
      .i_valid(valid[k]),
      .o_ready(ready[k]),
      .o_out  (sout[k]),
      .o_frame(frame[k]),
      .o_busy (busy[k])
    );
  end

  typedef struct {
    int           a;
    int           s;
    logic [W-1:0] w;
  } ent_t;

  typedef struct {
    int           k;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int           nw;
    int           exp_nf;
    int           exp_sp;
    int           exp_ones;
    logic [W-1:0] exp_rx0;
    logic [W-1:0] exp_rx1;
  } vec_t;

  ent_t          mq   [ND][$];
  logic [W-1:0]  accq [ND][$];
  int            last_s [ND];
  int            nacc [ND];
  int            nrx  [ND];
  int            rxn  [ND];
  logic [W-1:0]  rx   [ND];
  int            t;
  bit            chk_en;
  logic [ND-1:0] xf;
  int            nchk, nfail;

  task automatic chk(input string nm, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d t=%0d: got %h expected %h", nm, k, t, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int k, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d t=%0d: got %b expected %b", nm, k, t, act, exp);
    end
  endtask

  // One clock: sample handshake before the edge, update the model at the
  // edge, compare every instance at the following negedge.
  task automatic cycle();
    logic          rs;
    logic [ND-1:0] xfl;
    ent_t          e;
    logic          eo, ef, eb, eh;
    int            ix, sn;
    #1;
    rs  = rst;
    xfl = valid & ready;
    @(posedge clk);
    t++;
    xf = xfl;
    for (int k = 0; k < ND; k++) begin
      if (rs) begin
        nacc[k] -= accq[k].size();
        mq[k].delete();
        accq[k].delete();
        last_s[k] = -1000;
        rxn[k]    = 0;
      end else if (xfl[k]) begin
        sn  = (last_s[k] + W + GAPS[k] > t) ? last_s[k] + W + GAPS[k] : t;
        e.a = t;
        e.s = sn;
        e.w = data[k];
        mq[k].push_back(e);
        accq[k].push_back(data[k]);
        last_s[k] = sn;
        nacc[k]++;
      end
    end
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < ND; k++) begin
        while (mq[k].size() > 0 && mq[k][0].s + W + GAPS[k] <= t) void'(mq[k].pop_front());
        eo = 1'b0; ef = 1'b0; eb = 1'b0; eh = 1'b0;
        for (int i = 0; i < mq[k].size(); i++) begin
          e = mq[k][i];
          if (t >= e.s && t < e.s + W) begin
            ix = W - 1 - (t - e.s);
            eo = e.w[ix];
            ef = (t == e.s);
          end
          if (t >= e.s && t < e.s + W + GAPS[k]) eb = 1'b1;
          if (e.a <= t && t < e.s) begin
            eh = 1'b1;
            eb = 1'b1;
          end
        end
        chk1("o_out", k, sout[k], eo);
        chk1("o_frame", k, frame[k], ef);
        chk1("o_busy", k, busy[k], eb);
        chk1("o_ready", k, ready[k], !rst && !eh);
        // LSB-entry receiver: collects WIDTH bits starting at each frame bit.
        if (frame[k] === 1'b1) begin
          rx[k]  = W'(sout[k]);
          rxn[k] = 1;
        end else if (rxn[k] > 0) begin
          rx[k]  = {rx[k][W-2:0], sout[k]};
          rxn[k]++;
        end
        if (rxn[k] == W) begin
          rxn[k] = 0;
          nrx[k]++;
          if (accq[k].size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL rx_extra_word dut%0d t=%0d: got %h expected no word", k, t, rx[k]);
          end else begin
            chk("rx_word", k, rx[k], accq[k].pop_front());
          end
        end
      end
    end
  endtask

  // Push one or two words into one instance, record its line for 128 cycles
  // and check frame count, spacing, received words and total ones.
  task automatic run_vec(input vec_t v);
    logic [127:0] bits;
    logic [W-1:0] r0, r1;
    int           sent, nf, f0, f1, ones;
    bits = '0; r0 = '0; r1 = '0;
    sent = 0; nf = 0; f0 = 0; f1 = 0; ones = 0;
    for (int i = 0; i < 128; i++) begin
      valid = '0;
      if (sent < v.nw) begin
        valid[v.k] = 1'b1;
        data[v.k]  = (sent == 0) ? v.w0 : v.w1;
      end
      cycle();
      if (xf[v.k]) sent++;
      bits[i] = sout[v.k];
      if (frame[v.k] === 1'b1) begin
        if (nf == 0) f0 = i;
        else if (nf == 1) f1 = i;
        nf++;
      end
      if (sout[v.k] === 1'b1) ones++;
    end
    valid = '0;
    chk("vec_frames", v.k, nf, v.exp_nf);
    chk("vec_ones", v.k, ones, v.exp_ones);
    if (nf >= 1 && f0 + W <= 128) begin
      for (int j = 0; j < W; j++) r0 = {r0[W-2:0], bits[f0 + j]};
      chk("vec_rx0", v.k, r0, v.exp_rx0);
    end
    if (v.nw == 2 && nf >= 2) begin
      chk("vec_spacing", v.k, f1 - f0, v.exp_sp);
      if (f1 + W <= 128) begin
        for (int j = 0; j < W; j++) r1 = {r1[W-2:0], bits[f1 + j]};
        chk("vec_rx1", v.k, r1, v.exp_rx1);
      end
    end
  endtask

  vec_t vecs [4];
  vec_t post_rst;
  int   base [ND];
  int   tgt  [ND];
  int   cyc, nz_ones, nz_frames;
  bit   pending;

  initial begin
    vecs[0] = '{k:0, w0:32'h8000_0001, w1:32'h0,         nw:1, exp_nf:1, exp_sp:0,  exp_ones:2,  exp_rx0:32'h8000_0001, exp_rx1:32'h0};
    vecs[1] = '{k:0, w0:32'hA5A5_A5A5, w1:32'h0F0F_0F0F, nw:2, exp_nf:2, exp_sp:32, exp_ones:32, exp_rx0:32'hA5A5_A5A5, exp_rx1:32'h0F0F_0F0F};
    vecs[2] = '{k:1, w0:32'hDEAD_BEEF, w1:32'h1357_9BDF, nw:2, exp_nf:2, exp_sp:35, exp_ones:44, exp_rx0:32'hDEAD_BEEF, exp_rx1:32'h1357_9BDF};
    vecs[3] = '{k:2, w0:32'h0000_0001, w1:32'hFFFF_FFFE, nw:2, exp_nf:2, exp_sp:43, exp_ones:32, exp_rx0:32'h0000_0001, exp_rx1:32'hFFFF_FFFE};
    post_rst = '{k:0, w0:32'h0000_CAFE, w1:32'h0, nw:1, exp_nf:1, exp_sp:0, exp_ones:11, exp_rx0:32'h0000_CAFE, exp_rx1:32'h0};

    rst = 1'b1; valid = '0; t = 0; chk_en = 1'b0; nchk = 0; nfail = 0; xf = '0;
    for (int k = 0; k < ND; k++) begin
      data[k] = '0; last_s[k] = -1000; nacc[k] = 0; nrx[k] = 0; rxn[k] = 0; rx[k] = '0;
    end
    cycle();
    cycle();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Idle line after reset.
    for (int i = 0; i < 10; i++) begin
      cycle();
      for (int k = 0; k < ND; k++) begin
        chk1("rst_idle_out", k, sout[k], 1'b0);
        chk1("rst_idle_frame", k, frame[k], 1'b0);
        chk1("rst_idle_busy", k, busy[k], 1'b0);
        chk1("rst_idle_ready", k, ready[k], 1'b1);
      end
    end

    for (int v = 0; v < 4; v++) run_vec(vecs[v]);

    // Reset while bit 10 of 0xFFFFFFFF is on the line, 0x12345678 held.
    valid[0] = 1'b1;
    data[0]  = 32'hFFFF_FFFF;
    cycle();
    chk1("rm_accept0", 0, xf[0], 1'b1);
    chk1("rm_frame", 0, frame[0], 1'b1);
    data[0] = 32'h1234_5678;
    cycle();
    chk1("rm_accept1", 0, xf[0], 1'b1);
    chk1("rm_hold_full", 0, ready[0], 1'b0);
    valid = '0;
    for (int i = 0; i < 9; i++) cycle();
    chk1("rm_bit10", 0, sout[0], 1'b1);
    rst = 1'b1;
    cycle();
    chk1("rm_out_after_rst", 0, sout[0], 1'b0);
    chk1("rm_frame_after_rst", 0, frame[0], 1'b0);
    chk1("rm_busy_after_rst", 0, busy[0], 1'b0);
    chk1("rm_ready_in_rst", 0, ready[0], 1'b0);
    rst = 1'b0;
    cycle();
    chk1("rm_buf_empty", 0, ready[0], 1'b1);
    chk1("rm_busy_idle", 0, busy[0], 1'b0);
    nz_ones = 0; nz_frames = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (sout[0] !== 1'b0) nz_ones++;
      if (frame[0] !== 1'b0) nz_frames++;
    end
    chk("rm_no_bits", 0, nz_ones, 0);
    chk("rm_no_frames", 0, nz_frames, 0);
    run_vec(post_rst);

    // Random traffic, 50% valid, 1000 words across the three GAP settings.
    tgt[0] = 400; tgt[1] = 300; tgt[2] = 300;
    for (int k = 0; k < ND; k++) base[k] = nacc[k];
    cyc = 0;
    pending = 1'b1;
    while (pending && cyc < 40000) begin
      pending = 1'b0;
      for (int k = 0; k < ND; k++) begin
        if (nacc[k] - base[k] < tgt[k]) begin
          valid[k] = 1'($urandom_range(0, 1));
          data[k]  = $urandom;
          pending  = 1'b1;
        end else begin
          valid[k] = 1'b0;
        end
      end
      cycle();
      cyc++;
    end
    valid = '0;
    for (int k = 0; k < ND; k++) chk("rand_words", k, nacc[k] - base[k], tgt[k]);
    cyc = 0;
    while (busy !== '0 && cyc < 300) begin
      cycle();
      cyc++;
    end
    for (int i = 0; i < 5; i++) cycle();
    chk("drain_idle", 0, W'(busy), 0);
    for (int k = 0; k < ND; k++) begin
      chk("rand_rx_count", k, nrx[k], nacc[k]);
      chk("rand_left", k, accq[k].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
